// File: rtl/mfp_ahb_interconnect.sv
// mfp_ahb_interconnect
//
// AHB-lite single-master interconnect for the MIPSfpga system. The master
// address phase is decoded into NSLV one-hot slave selects, and the selected
// slave's data-phase response is steered back to the master. Addresses that
// hit no window during an active transfer go to a built-in default slave,
// which answers with the two-cycle AHB ERROR response. Every ERROR completion
// is counted in a saturating counter and its address is kept for software.
//
// Parameters:
//   NSLV       number of slaves (1..16)
//   SLV_BASE   packed NSLV x 32 window base addresses, slave i in [32*i+31:32*i]
//   SLV_MASK   packed NSLV x 32 window compare masks
//   ERR_CNT_W  width of the error counter
//
// Ports:
//   HCLK, HRESETn            bus clock, asynchronous active-low reset
//   HADDR, HTRANS            master address phase
//   HREADY, HRESP, HRDATA    response to the master (HREADY also to slaves)
//   HSEL                     one-hot address-phase slave select
//   S_HRDATA, S_HREADYOUT,
//   S_HRESP                  per-slave data-phase responses
//   err_clr                  synchronous clear of err_cnt
//   err_cnt, err_addr        error count and address of the latest ERROR

module mfp_ahb_interconnect #(
    parameter int                 NSLV      = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE  = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0] SLV_MASK  = {NSLV{32'h0}},
    parameter int                 ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    output logic                 HREADY,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [NSLV-1:0]      HSEL,
    input  logic [NSLV*32-1:0]   S_HRDATA,
    input  logic [NSLV-1:0]      S_HREADYOUT,
    input  logic [NSLV-1:0]      S_HRESP,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          err_addr
);

    localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } dflt_state_e;

    logic                 hit;
    logic [SEL_W-1:0]     hit_idx;
    logic                 unmapped;

    logic [SEL_W-1:0]     dp_sel_q, dp_sel_d;
    logic                 dp_act_q, dp_act_d;
    logic                 dp_dflt_q, dp_dflt_d;
    logic [31:0]          dp_addr_q, dp_addr_d;

    dflt_state_e          dflt_state_q, dflt_state_d;
    logic                 dflt_ready;
    logic                 dflt_resp;

    logic [31:0]          slv_rdata;
    logic                 slv_ready;
    logic                 slv_resp;

    logic                 err_done;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]          err_addr_q, err_addr_d;

    // Only the "active transfer" bit of HTRANS matters here; SEQ and NONSEQ
    // are treated identically, as are IDLE and BUSY.
    logic                 unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // The scan runs from the highest index down so the lowest matching
    // window is the last one written, which keeps overlapping windows one-hot.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((HADDR & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        HSEL = '0;
        for (int i = 0; i < NSLV; i++) begin
            HSEL[i] = hit && (hit_idx == SEL_W'(i));
        end
    end

    assign unmapped = HTRANS[1] & ~hit;

    // Address phase is captured only when the previous data phase completes.
    always_comb begin
        dp_sel_d  = dp_sel_q;
        dp_act_d  = dp_act_q;
        dp_dflt_d = dp_dflt_q;
        dp_addr_d = dp_addr_q;
        if (HREADY) begin
            dp_sel_d  = hit_idx;
            dp_act_d  = HTRANS[1] & hit;
            dp_dflt_d = unmapped;
            dp_addr_d = HADDR;
        end
    end

    // In ERR2 HREADY is always high, so a new unmapped transfer seen there
    // chains straight into the next ERR1 without an idle cycle.
    always_comb begin
        dflt_state_d = dflt_state_q;
        dflt_ready   = 1'b1;
        dflt_resp    = 1'b0;
        case (dflt_state_q)
            DS_IDLE: begin
                if (HREADY && unmapped) begin
                    dflt_state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                dflt_ready   = 1'b0;
                dflt_resp    = 1'b1;
                dflt_state_d = DS_ERR2;
            end
            DS_ERR2: begin
                dflt_resp    = 1'b1;
                dflt_state_d = unmapped ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                dflt_state_d = DS_IDLE;
            end
        endcase
    end

    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (dp_sel_q == SEL_W'(i)) begin
                slv_rdata = S_HRDATA[32*i +: 32];
                slv_ready = S_HREADYOUT[i];
                slv_resp  = S_HRESP[i];
            end
        end
    end

    // No transfer in the data phase means a zero-wait OKAY with zero data.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (dp_act_q) begin
            HREADY = slv_ready;
            HRESP  = slv_resp;
            HRDATA = slv_rdata;
        end else if (dp_dflt_q) begin
            HREADY = dflt_ready;
            HRESP  = dflt_resp;
        end
    end

    // A clear that coincides with a completion leaves a count of one so the
    // new error is not swallowed by the clear.
    assign err_done = HREADY & HRESP;

    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (err_done) begin
            err_addr_d = dp_addr_q;
            if (err_clr) begin
                err_cnt_d = ERR_CNT_W'(1);
            end else if (!(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_sel_q     <= '0;
            dp_act_q     <= 1'b0;
            dp_dflt_q    <= 1'b0;
            dp_addr_q    <= '0;
            dflt_state_q <= DS_IDLE;
            err_cnt_q    <= '0;
            err_addr_q   <= '0;
        end else begin
            dp_sel_q     <= dp_sel_d;
            dp_act_q     <= dp_act_d;
            dp_dflt_q    <= dp_dflt_d;
            dp_addr_q    <= dp_addr_d;
            dflt_state_q <= dflt_state_d;
            err_cnt_q    <= err_cnt_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// tb_mfp_ahb_interconnect
//
// Bench for mfp_ahb_interconnect with four slaves (two overlapping windows)
// and a 2-bit error counter. A driver issues AHB address phases and plays
// the slaves' data phases; each accepted address phase pushes its expected
// response into a queue, and an independent monitor pops and compares it
// when the interconnect completes the data phase.

module tb_mfp_ahb_interconnect;

    localparam int NSLV    = 4;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [31:0] WBASE [NSLV] = '{32'h00000000, 32'h1F400000, 32'h1F800000, 32'hBF000000};
    localparam logic [31:0] WMASK [NSLV] = '{32'hFFF00000, 32'hFFC00000, 32'h1FC00000, 32'hFF000000};

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic                HCLK        = 1'b0;
    logic                HRESETn     = 1'b0;
    logic [31:0]         HADDR       = '0;
    logic [1:0]          HTRANS      = '0;
    logic                HREADY;
    logic                HRESP;
    logic [31:0]         HRDATA;
    logic [NSLV-1:0]     HSEL;
    logic [NSLV*32-1:0]  S_HRDATA    = '0;
    logic [NSLV-1:0]     S_HREADYOUT = '1;
    logic [NSLV-1:0]     S_HRESP     = '0;
    logic                err_clr     = 1'b0;
    logic [CW-1:0]       err_cnt;
    logic [31:0]         err_addr;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        resp;
        logic        dflt;
        int          waits;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    bit abort  = 0;

    // Bench-side slave state for the data phase in flight.
    bit          dp_valid = 0;
    int          dp_slv   = 0;
    int          dp_wait  = 0;
    bit          dp_err   = 0;
    logic [31:0] dp_data  = '0;

    mfp_ahb_interconnect #(
        .NSLV      (NSLV),
        .SLV_BASE  ({WBASE[3], WBASE[2], WBASE[1], WBASE[0]}),
        .SLV_MASK  ({WMASK[3], WMASK[2], WMASK[1], WMASK[0]}),
        .ERR_CNT_W (CW)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .HSEL        (HSEL),
        .S_HRDATA    (S_HRDATA),
        .S_HREADYOUT (S_HREADYOUT),
        .S_HRESP     (S_HRESP),
        .err_clr     (err_clr),
        .err_cnt     (err_cnt),
        .err_addr    (err_addr)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got no finish want finish before 400us");
        $fatal(1, "[TB] watchdog expired");
    end

    // First window in table order that matches the address, or -1.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NSLV; i++) begin
            if ((a & WMASK[i]) == (WBASE[i] & WMASK[i])) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Unselected slaves return random junk so the mux must isolate them.
    task automatic drive_slaves();
        for (int j = 0; j < NSLV; j++) begin
            S_HRDATA[j*32 +: 32] = $urandom;
            S_HREADYOUT[j]       = 1'($urandom_range(0, 1));
            S_HRESP[j]           = 1'($urandom_range(0, 1));
        end
        if (dp_valid) begin
            S_HREADYOUT[dp_slv] = (dp_wait == 0);
            S_HRESP[dp_slv]     = (dp_wait == 0) && dp_err;
            if (dp_wait == 0) S_HRDATA[dp_slv*32 +: 32] = dp_data;
        end
    endtask

    // Called at posedge+1. Junk address phases are shown while the bus is
    // stalled; the real one goes out in the cycle HREADY is high.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans, input int waits,
                                 input bit err, input logic [31:0] data, input bit clr);
        int   guard;
        int   idx;
        exp_t e;
        if (abort) return;
        guard = 0;
        forever begin
            drive_slaves();
            HADDR   = $urandom;
            HTRANS  = 2'($urandom_range(0, 3));
            err_clr = 1'b0;
            @(negedge HCLK);
            if (HREADY === 1'b1) break;
            @(posedge HCLK);
            #1;
            if (dp_valid && dp_wait > 0) dp_wait--;
            guard++;
            if (guard > 40) begin
                checks++;
                errors++;
                $display("[TB] FAIL stall_timeout addr=%h got HREADY=%b want 1 within 40 cycles", addr, HREADY);
                abort = 1;
                return;
            end
        end
        HADDR   = addr;
        HTRANS  = trans;
        err_clr = clr;
        idx     = ref_decode(addr);
        #1;
        checkOutput("hsel", 32'(HSEL), (idx < 0) ? 32'h0 : (32'h1 << idx));
        @(posedge HCLK);
        #1;
        e.addr = addr;
        e.dflt = 1'b0;
        if (!trans[1]) begin
            e.rdata = '0; e.resp = 1'b0; e.waits = 0;
            dp_valid = 0;
        end else if (idx < 0) begin
            e.rdata = '0; e.resp = 1'b1; e.waits = 1; e.dflt = 1'b1;
            dp_valid = 0;
        end else begin
            e.rdata = data; e.resp = err; e.waits = waits;
            dp_valid = 1; dp_slv = idx; dp_wait = waits; dp_err = err; dp_data = data;
        end
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; reset hits the cycle in flight, outputs must
    // return to idle immediately.
    task automatic applyReset(input string tag);
        if (abort) return;
        drive_slaves();
        HTRANS  = T_IDLE;
        err_clr = 1'b0;
        #1;
        HRESETn = 1'b0;
        #1;
        checkOutput({tag, "_hready"}, 32'(HREADY), 32'h1);
        checkOutput({tag, "_hresp"}, 32'(HRESP), 32'h0);
        checkOutput({tag, "_hrdata"}, HRDATA, 32'h0);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
        checkOutput({tag, "_err_addr"}, err_addr, 32'h0);
        @(posedge HCLK);
        #1;
        HRESETn  = 1'b1;
        dp_valid = 0;
    endtask

    // Monitor: runs 2 time units after each falling edge, once all driver
    // inputs for the cycle have settled.
    initial begin
        int          stall;
        int          m_cnt;
        logic [31:0] m_addr;
        exp_t        e;
        bit          done;
        stall  = 0;
        m_cnt  = 0;
        m_addr = '0;
        forever begin
            @(negedge HCLK);
            #2;
            if (HRESETn !== 1'b1) begin
                exp_q.delete();
                stall  = 0;
                m_cnt  = 0;
                m_addr = '0;
            end else begin
                checkOutput("err_cnt", 32'(err_cnt), 32'(m_cnt));
                checkOutput("err_addr", err_addr, m_addr);
                done = 0;
                if (exp_q.size() == 0) begin
                    checkOutput("idle_hready", 32'(HREADY), 32'h1);
                    checkOutput("idle_hresp", 32'(HRESP), 32'h0);
                    checkOutput("idle_hrdata", HRDATA, 32'h0);
                end else if (HREADY !== 1'b1) begin
                    stall++;
                    checkOutput("stall_hresp", 32'(HRESP), 32'(exp_q[0].dflt));
                    if (stall > 40) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL monitor_stall got %0d stall cycles want at most 40", stall);
                        abort = 1;
                        exp_q.delete();
                        stall = 0;
                    end
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("hrdata", HRDATA, e.rdata);
                    checkOutput("hresp", 32'(HRESP), 32'(e.resp));
                    checkOutput("wait_cycles", 32'(stall), 32'(e.waits));
                    done  = e.resp;
                    stall = 0;
                end
                if (err_clr === 1'b1) begin
                    m_cnt = done ? 1 : 0;
                end else if (done && m_cnt < CNT_MAX) begin
                    m_cnt++;
                end
                if (done) m_addr = e.addr;
            end
        end
    end

    initial begin
        logic [31:0] addr;
        int          pick;
        $display("[TB] start");
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #2;
        checkOutput("reset_hready", 32'(HREADY), 32'h1);
        checkOutput("reset_hresp", 32'(HRESP), 32'h0);
        checkOutput("reset_hrdata", HRDATA, 32'h0);
        checkOutput("reset_err_cnt", 32'(err_cnt), 32'h0);
        checkOutput("reset_err_addr", err_addr, 32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Zero-wait read, then a 3-wait slave, then a plain read.
        applyStimulus(32'hBF800010, T_NONSEQ, 0, 0, 32'hCAFEF00D, 0);
        applyStimulus(32'h1F400020, T_NONSEQ, 3, 0, $urandom, 0);
        applyStimulus(32'h00000100, T_NONSEQ, 0, 0, $urandom, 0);

        // Unmapped access, then IDLE and BUSY to the same address.
        applyStimulus(32'h40000000, T_NONSEQ, 0, 0, 0, 0);
        applyStimulus(32'h40000000, T_IDLE, 0, 0, 0, 0);
        applyStimulus(32'h40000000, T_BUSY, 0, 0, 0, 0);

        // Two back-to-back unmapped accesses, then a read in the overlap.
        applyStimulus(32'h40000004, T_NONSEQ, 0, 0, 0, 0);
        applyStimulus(32'h80000000, T_NONSEQ, 0, 0, 0, 0);
        applyStimulus(32'hBFA00000, T_SEQ, 1, 0, $urandom, 0);
        applyStimulus(32'hBF123456, T_NONSEQ, 0, 0, $urandom, 0);

        // Real slave error, cleared in its completion cycle, then a lone clear.
        applyStimulus(32'hBF123458, T_NONSEQ, 2, 1, $urandom, 0);
        applyStimulus(32'h00000000, T_IDLE, 0, 0, 0, 1);
        applyStimulus(32'h00000000, T_IDLE, 0, 0, 0, 0);
        applyStimulus(32'h00000000, T_IDLE, 0, 0, 0, 1);

        // Five errors saturate the 2-bit counter; then clear alone.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(32'h40000000 + 32'(k * 16), T_NONSEQ, 0, 0, 0, 0);
        end
        applyStimulus(32'h00000010, T_IDLE, 0, 0, 0, 0);
        applyStimulus(32'h00000010, T_IDLE, 0, 0, 0, 1);
        applyStimulus(32'h00000010, T_IDLE, 0, 0, 0, 0);

        // Reset during ERR1, then during a wait state.
        applyStimulus(32'h60000000, T_NONSEQ, 0, 0, 0, 0);
        applyReset("rst_err1");
        applyStimulus(32'h1F400040, T_NONSEQ, 0, 0, $urandom, 0);
        applyStimulus(32'h00000200, T_NONSEQ, 3, 0, $urandom, 0);
        applyReset("rst_wait");
        applyStimulus(32'hBF800020, T_NONSEQ, 0, 0, $urandom, 0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 5);
            if (pick < NSLV) addr = WBASE[pick] | ($urandom & ~WMASK[pick]);
            else             addr = $urandom;
            applyStimulus(addr, 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0,
                          ($urandom_range(0, 7) == 0), $urandom,
                          ($urandom_range(0, 15) == 0));
        end

        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'h0, T_IDLE, 0, 0, 0, 0);
        end
        @(negedge HCLK);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
